// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: oversampling constants, receiver
//                state encoding and frame-format levels common to TX and RX.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Oversampling: 16 ticks per bit, centre of a bit is 7 ticks after an edge
    localparam int         OS_RATE = 16;
    localparam logic [3:0] OS_MID  = 4'd7;
    localparam logic [3:0] OS_LAST = 4'(OS_RATE - 1);

    // Frame format shared with the transmitter
    localparam logic LINE_IDLE         = 1'b1;
    localparam logic START_LEVEL       = 1'b0;
    localparam logic STOP_LEVEL        = 1'b1;
    localparam int   DATA_BITS_MIN     = 5;
    localparam int   DATA_BITS_MAX     = 9;
    localparam int   DATA_BITS_DEFAULT = 8;

    // Receiver FSM encoding
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sync2
//  Description : Generic two-flop synchronizer for a single asynchronous
//                input, with a configurable reset value.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_sync2 #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; the first may go metastable, the second filters it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_core
//  Description : UART receiver. Oversamples the line at 16x baud, validates
//                the start bit at its centre, samples data bits LSB first and
//                emits a one-cycle valid or framing-error strobe per frame.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 tick16,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_busy
);

    localparam int             BIT_W    = $clog2(DATA_BITS + 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    logic                 rx_s;

    uart_rx_state_t       state,        state_n;
    logic [3:0]           tick_cnt,     tick_cnt_n;
    logic [BIT_W-1:0]     bit_cnt,      bit_cnt_n;
    logic [DATA_BITS-1:0] shift_reg,    shift_reg_n;
    logic [DATA_BITS-1:0] rx_data_n;
    logic                 rx_valid_n;
    logic                 rx_frame_err_n;

    // Bring the asynchronous line into the clk domain; idles high
    uart_sync2 #(
        .RESET_VALUE (LINE_IDLE)
    ) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // State, counters, shift register and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            state        <= state_n;
            tick_cnt     <= tick_cnt_n;
            bit_cnt      <= bit_cnt_n;
            shift_reg    <= shift_reg_n;
            rx_data      <= rx_data_n;
            rx_valid     <= rx_valid_n;
            rx_frame_err <= rx_frame_err_n;
        end
    end

    // Next-state logic; everything holds except on tick16, strobes default low
    always_comb begin
        state_n        = state;
        tick_cnt_n     = tick_cnt;
        bit_cnt_n      = bit_cnt;
        shift_reg_n    = shift_reg;
        rx_data_n      = rx_data;
        rx_valid_n     = 1'b0;
        rx_frame_err_n = 1'b0;

        if (tick16) begin
            case (state)
                ST_IDLE: begin
                    if (rx_s == START_LEVEL) begin
                        state_n    = ST_START;
                        tick_cnt_n = '0;
                    end
                end

                ST_START: begin
                    if (tick_cnt == OS_MID) begin
                        if (rx_s == START_LEVEL) begin
                            state_n    = ST_DATA;
                            tick_cnt_n = '0;
                            bit_cnt_n  = '0;
                        end else begin
                            // Line went back high before mid-bit: a glitch
                            state_n = ST_IDLE;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt + 4'd1;
                    end
                end

                ST_DATA: begin
                    tick_cnt_n = tick_cnt + 4'd1;
                    if (tick_cnt == OS_LAST) begin
                        shift_reg_n = {rx_s, shift_reg[DATA_BITS-1:1]};
                        bit_cnt_n   = bit_cnt + BIT_ONE;
                        if (bit_cnt == LAST_BIT) begin
                            state_n = ST_STOP;
                        end
                    end
                end

                ST_STOP: begin
                    tick_cnt_n = tick_cnt + 4'd1;
                    if (tick_cnt == OS_LAST) begin
                        if (rx_s == STOP_LEVEL) begin
                            rx_data_n  = shift_reg;
                            rx_valid_n = 1'b1;
                            state_n    = ST_IDLE;
                        end else begin
                            rx_frame_err_n = 1'b1;
                            state_n        = ST_BREAK;
                        end
                    end
                end

                ST_BREAK: begin
                    // Wait for the line to recover so a held-low line errors once
                    if (rx_s == LINE_IDLE) begin
                        state_n = ST_IDLE;
                    end
                end

                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    assign rx_busy = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_uart_rx_core
//  Description : Self-checking bench for uart_rx_core (8-bit and 7-bit
//                instances) with a queue-based scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_core;

    localparam int CLK_DIV = 4;              // clk cycles per tick16
    localparam int BIT_CLK = CLK_DIV * 16;   // clk cycles per nominal bit

    typedef struct {
        logic       is_err;
        logic [8:0] data;
        int         lat;      // expected ticks from line fall to strobe, 0 = unchecked
    } exp_t;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       tick16 = 1'b0;
    logic       rx8    = 1'b1;
    logic       rx7    = 1'b1;
    logic [7:0] data8;
    logic       valid8, ferr8, busy8;
    logic [6:0] data7;
    logic       valid7, ferr7, busy7;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   ph       = 0;
    int   tick_idx = 0;
    int   fall8    = 0;
    int   fall7    = 0;
    exp_t q8[$];
    exp_t q7[$];
    logic [7:0] last8 = 8'h00;

    uart_rx_core #(.DATA_BITS(8)) dut8 (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx8),
        .tick16       (tick16),
        .rx_data      (data8),
        .rx_valid     (valid8),
        .rx_frame_err (ferr8),
        .rx_busy      (busy8)
    );

    uart_rx_core #(.DATA_BITS(7)) dut7 (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx7),
        .tick16       (tick16),
        .rx_data      (data7),
        .rx_valid     (valid7),
        .rx_frame_err (ferr7),
        .rx_busy      (busy7)
    );

    always #5 clk = ~clk;

    // Baud generator stand-in: one tick every CLK_DIV clocks
    initial begin
        forever begin
            @(posedge clk);
            #2;
            ph     = (ph + 1) % CLK_DIV;
            tick16 = (ph == 0);
            if (tick16) tick_idx++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Scoreboard for the 8-bit receiver
    always @(negedge clk) begin
        exp_t e;
        if (!reset && (valid8 || ferr8)) begin
            check("excl8", 32'(valid8 & ferr8), 32'd0);
            if (q8.size() == 0) begin
                check("unexpected8", 32'({valid8, ferr8}), 32'd0);
            end else begin
                e = q8.pop_front();
                check("kind8", 32'(ferr8), 32'(e.is_err));
                check("data8", 32'(data8), 32'(e.data));
                if (e.lat > 0) check("lat8", 32'(tick_idx - fall8), 32'(e.lat));
            end
        end
    end

    // Scoreboard for the 7-bit receiver
    always @(negedge clk) begin
        exp_t e;
        if (!reset && (valid7 || ferr7)) begin
            check("excl7", 32'(valid7 & ferr7), 32'd0);
            if (q7.size() == 0) begin
                check("unexpected7", 32'({valid7, ferr7}), 32'd0);
            end else begin
                e = q7.pop_front();
                check("kind7", 32'(ferr7), 32'(e.is_err));
                check("data7", 32'(data7), 32'(e.data));
                if (e.lat > 0) check("lat7", 32'(tick_idx - fall7), 32'(e.lat));
            end
        end
    end

    task automatic push8(input logic is_err, input logic [8:0] d, input int lat);
        exp_t e;
        e.is_err = is_err; e.data = d; e.lat = lat;
        q8.push_back(e);
    endtask

    // Drive one frame; align starts the fall just after a tick, abort_bit >= 0
    // stops in the middle of that data bit
    task automatic send(input bit sel7, input logic [8:0] d, input int nbits,
                        input logic stop, input int bclk, input bit align,
                        input int abort_bit);
        logic b;
        if (align) while (ph != 1) @(negedge clk);
        if (sel7) fall7 = tick_idx; else fall8 = tick_idx;
        for (int i = 0; i < nbits + 2; i++) begin
            b = (i == 0) ? 1'b0 : (i == nbits + 1) ? stop : d[i-1];
            if (sel7) rx7 = b; else rx8 = b;
            if (abort_bit >= 0 && i == abort_bit + 1) begin
                repeat (bclk / 2) @(negedge clk);
                return;
            end
            repeat (bclk) @(negedge clk);
        end
    endtask

    initial begin
        int   bclks[3];
        logic seen;
        exp_t e7;
        bclks[0] = 64; bclks[1] = 66; bclks[2] = 62;

        // Reset state
        repeat (5) @(negedge clk);
        check("rst_data",  32'(data8),  32'd0);
        check("rst_valid", 32'(valid8), 32'd0);
        check("rst_ferr",  32'(ferr8),  32'd0);
        check("rst_busy",  32'(busy8),  32'd0);
        check("rst_data7", 32'(data7),  32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // Clean frame with exact latency
        push8(1'b0, 9'h0A5, 153);
        send(1'b0, 9'h0A5, 8, 1'b1, BIT_CLK, 1'b1, -1);
        last8 = 8'hA5;
        repeat (40) @(negedge clk);

        // Glitch: low for 4 ticks only
        while (ph != 1) @(negedge clk);
        seen = 1'b0;
        rx8  = 1'b0;
        for (int i = 0; i < 16; i++) begin @(negedge clk); seen |= busy8; end
        rx8 = 1'b1;
        for (int i = 0; i < 80; i++) begin @(negedge clk); seen |= busy8; end
        check("glitch_busy_seen", 32'(seen), 32'd1);
        check("glitch_idle", 32'(busy8), 32'd0);

        // Framing error followed by a held-low line
        push8(1'b1, {1'b0, last8}, 153);
        send(1'b0, 9'h03C, 8, 1'b0, BIT_CLK, 1'b1, -1);
        repeat (160) @(negedge clk);
        check("break_busy", 32'(busy8), 32'd1);
        rx8 = 1'b1;
        repeat (12) @(negedge clk);
        check("break_exit", 32'(busy8), 32'd0);
        repeat (40) @(negedge clk);
        push8(1'b0, 9'h011, 153);
        send(1'b0, 9'h011, 8, 1'b1, BIT_CLK, 1'b1, -1);
        last8 = 8'h11;
        repeat (40) @(negedge clk);

        // Back-to-back frames at nominal and +/-3% bit period
        foreach (bclks[k]) begin
            push8(1'b0, 9'h000, 0);
            push8(1'b0, 9'h0FF, 0);
            send(1'b0, 9'h000, 8, 1'b1, bclks[k], 1'b1, -1);
            send(1'b0, 9'h0FF, 8, 1'b1, bclks[k], 1'b0, -1);
            repeat (80) @(negedge clk);
        end
        last8 = 8'hFF;

        // Reset during data bit 4 of 0x5A
        send(1'b0, 9'h05A, 8, 1'b1, BIT_CLK, 1'b1, 4);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_data",  32'(data8),  32'd0);
        check("midrst_valid", 32'(valid8), 32'd0);
        check("midrst_ferr",  32'(ferr8),  32'd0);
        check("midrst_busy",  32'(busy8),  32'd0);
        rx8 = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        last8 = 8'h00;
        repeat (40) @(negedge clk);
        push8(1'b0, 9'h0C3, 153);
        send(1'b0, 9'h0C3, 8, 1'b1, BIT_CLK, 1'b1, -1);
        repeat (40) @(negedge clk);

        // Seven-bit frame on the second instance
        e7.is_err = 1'b0; e7.data = 9'h055; e7.lat = 137;
        q7.push_back(e7);
        send(1'b1, 9'h055, 7, 1'b1, BIT_CLK, 1'b1, -1);
        repeat (100) @(negedge clk);

        check("q8_drained", 32'(q8.size()), 32'd0);
        check("q7_drained", 32'(q7.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_core.md
# uart_rx_core

Asynchronous serial receiver for the UART subsystem. It is the receive-side counterpart of the transmitter and consumes the serial line that the transmitter drives. It oversamples the line at 16× baud using a tick from the shared baud generator, validates the start bit, and samples each data bit at its centre. Each completed frame is presented as a parallel word with a one-cycle valid strobe; a bad stop bit raises a framing-error strobe instead.

## Interface
Parameters:
- `DATA_BITS`, default 8: data bits per frame, LSB first; legal range 5–9.

Ports:
- `clk`: input, 1 bit. System clock.
- `reset`: input, 1 bit. Asynchronous, active-high.
- `rx`: input, 1 bit. Serial line, asynchronous to `clk`, idle high.
- `tick16`: input, 1 bit. One-`clk` pulse at 16× baud, from the baud generator.
- `rx_data`: output, `DATA_BITS` bits. Last correctly framed word; held until the next good frame.
- `rx_valid`: output, 1 bit. One-cycle pulse; `rx_data` is new.
- `rx_frame_err`: output, 1 bit. One-cycle pulse; the stop bit was sampled low.
- `rx_busy`: output, 1 bit. High whenever the FSM is not in IDLE.

## Operation
- **Synchronizer:** `rx` passes through 2 flops (reset value 1) to give `rx_s`. All FSM decisions use `rx_s` only.
- **Counters:**
  - `tick_cnt`: 4 bits, wraps 15→0.
  - `bit_cnt`: width ceil(log2(DATA_BITS+1)).
  - Shift register: `DATA_BITS` wide, shifts right, new bit inserted at the MSB.
- **Stalling:** the FSM and both counters advance only on cycles where `tick16` = 1. Otherwise all state holds.
- **States:**
  - **IDLE:** on a tick with `rx_s` = 0, go to START with `tick_cnt` ← 0.
  - **START:** on each tick, if `tick_cnt` = 7, sample `rx_s`:
    - 0: go to DATA with `tick_cnt` ← 0 and `bit_cnt` ← 0.
    - 1: treat as a glitch and return to IDLE with no output pulse.
    - Otherwise (`tick_cnt` ≠ 7), `tick_cnt`++.
  - **DATA:** on each tick, `tick_cnt`++. When `tick_cnt` = 15, shift `rx_s` in and increment `bit_cnt`. When `bit_cnt` reaches `DATA_BITS`, go to STOP.
  - **STOP:** on the tick where `tick_cnt` = 15, sample `rx_s`:
    - 1: `rx_data` ← shift register, pulse `rx_valid`, go to IDLE.
    - 0: pulse `rx_frame_err`, leave `rx_data` unchanged, go to BREAK.
  - **BREAK:** on a tick with `rx_s` = 1, go to IDLE. This prevents a line held low from producing repeated error frames.
- **Exclusivity:** `rx_valid` and `rx_frame_err` are never high in the same cycle.
- **No back-pressure:** the consumer must capture `rx_data` within one frame time. A new good frame overwrites `rx_data` unconditionally.
- **Reset values:**
  - FSM goes to IDLE.
  - `rx_data` = 0, `rx_valid` = 0, `rx_frame_err` = 0, `rx_busy` = 0.
  - Counters = 0; synchronizer flops = 1.
- **Reset mid-frame:** the partial frame is abandoned and no pulse is emitted. The next frame must start from a fresh falling edge.

## Timing
- **Input latency:** 2 `clk` from an `rx` edge to `rx_s`.
- **Frame latency:** take the start-detect tick as tick 0.
  - Start-centre sample: tick 8.
  - Data bit i sample: tick 8 + 16·(i+1).
  - Stop sample: tick 8 + 16·(DATA_BITS+1), which is tick 152 for 8 bits.
- **Strobes:** `rx_valid` / `rx_frame_err` are registered and high for exactly the one `clk` after the stop-sample tick. `rx_data` changes in that same cycle.
- **`rx_busy`:** goes high the `clk` after the start-detect tick and falls in the same cycle as the result strobe (or on leaving BREAK).
- **Back-to-back frames:** a start bit that immediately follows the stop bit is detected on the first IDLE tick that sees `rx_s` = 0. This tolerates up to about 7/16 bit of accumulated drift per frame.
- **Tick requirement:** `tick16` must have at least 2 `clk` between pulses.

## Structure
- **Shared package `uart_pkg`:**
  - `OS_RATE` = 16 and `OS_MID` = 7.
  - The enum `uart_rx_state_t` with states IDLE, START, DATA, STOP, BREAK.
  - Frame-format constants, shared with the transmitter.
- **Sub-module `uart_sync2`:** generic 2-flop synchronizer with a reset-value parameter. It is reused for other asynchronous inputs.
- **Bench clocking:** the top-level test harness instantiates the baud generator with divider `clk_freq / (baud·16)` to drive `tick16`.

## Test plan
- **Clean frame:** send frame 0xA5 at the nominal rate → exactly one `rx_valid` pulse with `rx_data` = 0xA5 at tick 152 + 1 `clk`; `rx_frame_err` stays 0.
- **Glitch rejection:** drive `rx` low for 4 ticks, then high → `rx_busy` pulses, FSM returns to IDLE, no `rx_valid` or `rx_frame_err`.
- **Framing error and break:**
  - Send 0x3C with a stop bit of 0, then hold `rx` low for 40 ticks → one `rx_frame_err`, `rx_data` keeps its previous value, and `rx_busy` stays high until `rx` returns high.
  - Then send 0x11 → `rx_valid` with 0x11.
- **Back-to-back frames:** send 0x00 then 0xFF with no idle gap → two `rx_valid` pulses in order; also repeat with the transmitter's bit period skewed ±3%, with the same result.
- **Reset mid-frame:** assert `reset` during data bit 4 of 0x5A → all outputs 0 and no pulse. Then send 0xC3 → `rx_valid` with 0xC3.
- **Seven-bit frames:** `DATA_BITS` = 7, send 0x55 → `rx_data` = 7'h55 with `rx_valid` at tick 8 + 16·8 = 136 + 1 `clk`.
